// File: rtl/pingpong_bank_ctrl_if.sv
// Producer/consumer handshake and lane FIFO strobe/flag bundle for the ping-pong bank controller.
// The slave modport is the controller; the master side is the datapath and its environment.
interface pingpong_bank_ctrl_if #(
  parameter int unsigned LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               out_ready;
  logic               out_valid;
  logic               rdata_vld;
  logic               rd_last;
  logic [2*LANES-1:0] fifo_wr;
  logic [2*LANES-1:0] fifo_rd;
  logic [2*LANES-1:0] fifo_empty;
  logic [2*LANES-1:0] fifo_full;
  logic               wr_bank;
  logic               rd_bank;
  logic [3:0]         fifo_state;
  logic               err;

  modport slave (
    input  in_valid, out_ready, fifo_empty, fifo_full,
    output in_ready, out_valid, rdata_vld, rd_last, fifo_wr, fifo_rd,
           wr_bank, rd_bank, fifo_state, err
  );

  modport master (
    output in_valid, out_ready, fifo_empty, fifo_full,
    input  in_ready, out_valid, rdata_vld, rd_last, fifo_wr, fifo_rd,
           wr_bank, rd_bank, fifo_state, err
  );
endinterface

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong bank sequencer: fills one bank of lane FIFOs row by row while draining the other,
// issues per-FIFO strobes and cross-checks the FIFO flags against the bank state.
module pingpong_bank_ctrl #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CWIDTH = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  pingpong_bank_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    StEmpty    = 2'b00,
    StFilling  = 2'b01,
    StFull     = 2'b10,
    StDraining = 2'b11
  } bank_st_e;

  localparam logic [2*LANES-1:0] Bank0Mask = {{LANES{1'b0}}, {LANES{1'b1}}};
  localparam logic [2*LANES-1:0] Bank1Mask = ~Bank0Mask;
  localparam logic [CWIDTH-1:0]  LastRow   = CWIDTH'(DEPTH - 1);

  bank_st_e          state_q [2];
  bank_st_e          state_d [2];
  logic [CWIDTH-1:0] wcnt_q  [2];
  logic [CWIDTH-1:0] wcnt_d  [2];
  logic [CWIDTH-1:0] rcnt_q  [2];
  logic [CWIDTH-1:0] rcnt_d  [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              err_q, err_d;
  logic              rdata_vld_q, rdata_vld_d;
  logic              rd_last_q, rd_last_d;
  logic              chk_en_q;

  logic              in_ready, out_valid, wr_beat, rd_beat;
  logic [1:0]        empty_ok, full_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= StEmpty;
        wcnt_q[b]  <= '0;
        rcnt_q[b]  <= '0;
      end
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      err_q       <= 1'b0;
      rdata_vld_q <= 1'b0;
      rd_last_q   <= 1'b0;
      chk_en_q    <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        wcnt_q[b]  <= wcnt_d[b];
        rcnt_q[b]  <= rcnt_d[b];
      end
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      err_q       <= err_d;
      rdata_vld_q <= rdata_vld_d;
      rd_last_q   <= rd_last_d;
      chk_en_q    <= 1'b1;
    end
  end

  always_comb begin
    in_ready  = (state_q[wr_bank_q] == StEmpty) || (state_q[wr_bank_q] == StFilling);
    out_valid = (state_q[rd_bank_q] == StFull) || (state_q[rd_bank_q] == StDraining);
    wr_beat   = bus.in_valid & in_ready;
    rd_beat   = out_valid & bus.out_ready;
  end

  // Write and read beats can never hit the same bank: their state preconditions are disjoint.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      wcnt_d[b]  = wcnt_q[b];
      rcnt_d[b]  = rcnt_q[b];
    end
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rdata_vld_d = rd_beat;
    rd_last_d   = 1'b0;

    if (wr_beat) begin
      if (wcnt_q[wr_bank_q] == LastRow) begin
        state_d[wr_bank_q] = StFull;
        wcnt_d[wr_bank_q]  = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = StFilling;
        wcnt_d[wr_bank_q]  = wcnt_q[wr_bank_q] + CWIDTH'(1);
      end
    end

    if (rd_beat) begin
      if (rcnt_q[rd_bank_q] == LastRow) begin
        state_d[rd_bank_q] = StEmpty;
        rcnt_d[rd_bank_q]  = '0;
        rd_bank_d          = ~rd_bank_q;
        rd_last_d          = 1'b1;
      end else begin
        state_d[rd_bank_q] = StDraining;
        rcnt_d[rd_bank_q]  = rcnt_q[rd_bank_q] + CWIDTH'(1);
      end
    end
  end

  always_comb begin
    empty_ok[0] = (bus.fifo_empty & Bank0Mask) == Bank0Mask;
    empty_ok[1] = (bus.fifo_empty & Bank1Mask) == Bank1Mask;
    full_ok[0]  = (bus.fifo_full & Bank0Mask) == Bank0Mask;
    full_ok[1]  = (bus.fifo_full & Bank1Mask) == Bank1Mask;
    err_d       = err_q;
    if (chk_en_q) begin
      for (int b = 0; b < 2; b++) begin
        if ((state_q[b] == StEmpty && !empty_ok[b]) || (state_q[b] == StFull && !full_ok[b])) begin
          err_d = 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.fifo_wr    = wr_beat ? (wr_bank_q ? Bank1Mask : Bank0Mask) : '0;
  assign bus.fifo_rd    = rd_beat ? (rd_bank_q ? Bank1Mask : Bank0Mask) : '0;
  assign bus.rdata_vld  = rdata_vld_q;
  assign bus.rd_last    = rd_last_q;
  assign bus.wr_bank    = wr_bank_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.fifo_state = {state_q[1], state_q[0]};
  assign bus.err        = err_q;

endmodule

// File: doc/pingpong_bank_ctrl.md
Name: pingpong_bank_ctrl

Overview:
Sequencing controller for the ping-pong data buffer. The buffer has 2 banks of LANES lane FIFOs each, and every lane FIFO holds DEPTH entries.
- Accepts a producer valid/ready stream and writes whole rows into the active write bank.
- Hands a completely filled bank to the consumer and drains it.
- Alternates banks so that filling one bank overlaps draining the other.
- Generates all per-FIFO wr/rd strobes and checks FIFO flags for consistency.

Parameters:
LANES, 4, lane FIFOs per bank. Total FIFOs = 2*LANES. Bank 0 = FIFO indices 0..LANES-1, bank 1 = LANES..2*LANES-1.
DEPTH, 4, entries per lane FIFO (rows per bank). Must be >=1.
CWIDTH, 3, row counter width. Must satisfy 2^CWIDTH > DEPTH.

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a row to write
in_ready  output  1  controller accepts a row this cycle
out_ready  input  1  consumer accepts a row read this cycle
out_valid  output  1  a readable (full/draining) bank exists
rdata_vld  output  1  lane FIFO read data valid (one cycle after read strobe)
rd_last  output  1  registered; marks the rdata_vld beat of the final row of a bank
fifo_wr  output  2*LANES  per-FIFO write strobes
fifo_rd  output  2*LANES  per-FIFO read strobes
fifo_empty  input  2*LANES  per-FIFO empty flags
fifo_full  input  2*LANES  per-FIFO full flags
wr_bank  output  1  bank currently targeted by writes
rd_bank  output  1  bank currently targeted by reads
fifo_state  output  4  {bank1_state[1:0], bank0_state[1:0]}
err  output  1  sticky flag-consistency error

Behaviour:
- Bank state encoding, one 2-bit register per bank: EMPTY=00, FILLING=01, FULL=10, DRAINING=11.
- Reset (asynchronous, rst_n=0):
  - Both banks EMPTY; wr_bank=0, rd_bank=0; both row counters 0.
  - err=0, rdata_vld=0, rd_last=0; fifo_state=4'b0000.
- in_ready is combinational: 1 when state[wr_bank] is EMPTY or FILLING.
- Write beat = in_valid & in_ready.
  - In the same cycle, fifo_wr is asserted for all LANES FIFOs of wr_bank and 0 elsewhere.
  - No strobes are issued when in_ready=0.
- Write-side transitions on a write beat:
  - EMPTY->FILLING, or EMPTY->FULL when DEPTH=1.
  - Each beat increments wcnt[wr_bank].
  - The beat that makes the count DEPTH sets the state to FULL, clears wcnt, and toggles wr_bank on the same edge.
- out_valid is combinational: 1 when state[rd_bank] is FULL or DRAINING.
- Read beat = out_valid & out_ready.
  - In the same cycle, fifo_rd is asserted for all LANES FIFOs of rd_bank and 0 elsewhere.
- Read-side transitions on a read beat:
  - FULL->DRAINING.
  - Each beat increments rcnt[rd_bank].
  - The DEPTH-th beat sets the state to EMPTY, clears rcnt, and toggles rd_bank.
  - When DEPTH=1: FULL->EMPTY directly.
- rdata_vld is the read beat registered (1-cycle latency). rd_last is registered alongside it and is 1 on the final row's rdata_vld beat.
- Simultaneous write and read beats in one cycle are legal; they always target different banks.
- Write-to-readable latency: the FULL state is visible and out_valid=1 in the cycle after the last write beat.
- Back-pressure:
  - After wr_bank toggles, in_ready stays 0 while the new wr_bank is FULL or DRAINING.
  - in_ready rises in the cycle after that bank returns to EMPTY.
  - The producer may hold in_valid; no rows are lost or duplicated.
- Flag check, evaluated every cycle on registered state, for each bank b:
  - EMPTY: every lane of b must have fifo_empty=1.
  - FULL: every lane of b must have fifo_full=1.
  - Any violation sets err=1 on the next edge. err stays set until reset.
  - The check is suppressed in the first cycle after reset deasserts.
- Reset mid-operation returns all control state to reset values immediately. Lane FIFO contents are cleared by the shared rst_n.
- Strobes are never X: fifo_wr and fifo_rd are 0 whenever their beat condition is false.

Test Plan:
- Reset then idle, in_valid=0, out_ready=0 -> in_ready=1, out_valid=0, fifo_state=0000, fifo_wr=fifo_rd=0, err=0 for 10 cycles.
- 4 back-to-back write beats, out_ready=0 -> fifo_wr=0x0F each cycle; after the 4th, fifo_state=0010, wr_bank=1; the next 4 beats give fifo_wr=0xF0 and fifo_state=1010; then in_ready=0.
- Both banks FULL, out_ready=1 -> fifo_rd=0x0F for 4 cycles; rdata_vld follows 1 cycle later with rd_last on the 4th; bank0 goes EMPTY and in_ready=1 next cycle; then fifo_rd=0xF0 for 4 cycles.
- Continuous in_valid=1, out_ready=1 for 40 cycles -> in_valid&in_ready is high in every cycle after the first 4 (writes to one bank overlap reads from the other), no bank both written and read in one cycle, err=0.
- Model drives fifo_full[2]=0 while bank0 is FULL -> err=1 next cycle and stays 1 until rst_n is pulsed.
- Assert rst_n=0 mid-fill (bank0 wcnt=2) -> outputs immediately return to reset values; the next 4 writes fill bank0 from row 0.
